// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note-on/note-off to voice assignment with queued parameter-RAM writes
module voice_allocator #(
    parameter int VOICE_BITS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_note_on,
    input  logic [6:0]                    ev_note,
    input  logic [6:0]                    ev_velocity,
    input  logic                          upd_grant,
    output logic                          pram_we,
    output logic [VOICE_BITS-1:0]         pram_addr,
    output logic [15:0]                   pram_data,
    output logic [(1<<VOICE_BITS)-1:0]    voices_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int NV = 1 << VOICE_BITS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = VOICE_BITS + 16;

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE, ENQ} state_t;

    state_t state, state_nxt;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;

    logic                  cap_on;
    logic [6:0]            cap_note;
    logic [6:0]            cap_vel;
    logic [VOICE_BITS-1:0] scan_idx;
    logic                  match_found;
    logic [VOICE_BITS-1:0] match_idx;
    logic                  free_found;
    logic [VOICE_BITS-1:0] free_idx;
    logic [VOICE_BITS-1:0] steal_ptr;

    logic [NV-1:0]         gate;
    logic [6:0]            note_tab [NV];

    logic [VOICE_BITS-1:0] pay_addr;
    logic [15:0]           pay_data;

    logic [VOICE_BITS-1:0] dec_voice;
    logic                  dec_retrig;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    assign voices_active = gate;
    assign pop           = upd_grant && (fifo_count != '0);
    assign fifo_full     = (fifo_count == (PW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (&scan_idx) state_nxt = DECIDE;
            DECIDE:  state_nxt = (!cap_on && !match_found) ? IDLE : ENQ;
            ENQ:     if (push) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A full FIFO still accepts the push when the same edge pops an entry.
    always_comb begin
        ev_ready = (state == IDLE);
        accept   = ev_ready && ev_valid;
        push     = (state == ENQ) && (!fifo_full || pop);
    end

    // Priority: retrigger a matching voice, else take a free one, else steal round-robin.
    always_comb begin
        dec_voice  = steal_ptr;
        dec_retrig = 1'b1;
        if (match_found) begin
            dec_voice  = match_idx;
            dec_retrig = 1'b1;
        end else if (free_found) begin
            dec_voice  = free_idx;
            dec_retrig = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_on      <= 1'b0;
            cap_note    <= '0;
            cap_vel     <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            steal_ptr   <= '0;
            gate        <= '0;
            pay_addr    <= '0;
            pay_data    <= '0;
            for (int i = 0; i < NV; i++) begin
                note_tab[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_on      <= ev_note_on;
                        cap_note    <= ev_note;
                        cap_vel     <= ev_velocity;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (gate[scan_idx] && (note_tab[scan_idx] == cap_note) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!gate[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                DECIDE: begin
                    if (cap_on) begin
                        gate[dec_voice]     <= 1'b1;
                        note_tab[dec_voice] <= cap_note;
                        pay_addr            <= dec_voice;
                        pay_data            <= {1'b1, cap_note, cap_vel, dec_retrig};
                        if (!match_found && !free_found) begin
                            steal_ptr <= steal_ptr + 1'b1;
                        end
                    end else if (match_found) begin
                        gate[match_idx] <= 1'b0;
                        pay_addr        <= match_idx;
                        pay_data        <= {1'b0, note_tab[match_idx], cap_vel, 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pay_addr, pay_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pram_we    <= 1'b0;
            pram_addr  <= '0;
            pram_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            pram_we <= pop;
            if (pop) begin
                rd_ptr                 <= rd_ptr + 1'b1;
                {pram_addr, pram_data} <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
